// File: rtl/bht_pkg.sv
// Shared types for the branch history table: counter type, FSM states and
// the saturating counter step used by both the RTL and anything that models it.
package bht_pkg;

   typedef logic [1:0] ctr_t;

   typedef enum ctr_t {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_state_e;

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } fsm_e;

   localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;

   function automatic ctr_t sat_step(ctr_t c, logic taken);
      ctr_t r;
      if (taken) r = (c == ST)  ? c : c + 2'd1;
      else       r = (c == SNT) ? c : c - 2'd1;
      return r;
   endfunction

endpackage

// File: rtl/bht_ghr.sv
// Global history register and gshare index hash; history is zero-extended
// to the index width before being XORed into the PC index.
module bht_ghr #(
   parameter int IDX_W  = 8,
   parameter int HIST_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              upd_en_i,
   input  logic              taken_i,
   input  logic [IDX_W-1:0]  fetch_idx_i,
   input  logic [IDX_W-1:0]  ex_idx_i,
   input  logic [HIST_W-1:0] ex_ghr_i,
   output logic [HIST_W-1:0] ghr_o,
   output logic [IDX_W-1:0]  fetch_hidx_o,
   output logic [IDX_W-1:0]  ex_hidx_o
);

   logic [HIST_W-1:0] ghr_q, ghr_d;
   logic [IDX_W-1:0]  ghr_ext, ex_ghr_ext;

   always_comb begin
      ghr_d = ghr_q;
      if (upd_en_i) begin
         ghr_d    = ghr_q << 1;
         ghr_d[0] = taken_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ghr_q <= '0;
      else        ghr_q <= ghr_d;
   end

   always_comb begin
      ghr_ext                   = '0;
      ghr_ext[HIST_W-1:0]       = ghr_q;
      ex_ghr_ext                = '0;
      ex_ghr_ext[HIST_W-1:0]    = ex_ghr_i;
   end

   // Update uses the history captured at that branch's fetch, not the live one.
   assign fetch_hidx_o = fetch_idx_i ^ ghr_ext;
   assign ex_hidx_o    = ex_idx_i ^ ex_ghr_ext;
   assign ghr_o        = ghr_q;

endmodule

// File: rtl/bht_sat2.sv
// Tagged 2-bit saturating-counter branch history table with post-reset init
// sweep; define BHT_GSHARE_EN to XOR global history into the table index.
module bht_sat2
   import bht_pkg::*;
#(
   parameter int   ENTRIES    = 256,
   parameter int   PC_W       = 32,
   parameter int   HIST_W     = 8,
   parameter ctr_t INIT_STATE = 2'b01
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PC_W-1:0]   fetch_pc,
   input  logic [31:0]       fetch_inst,
   output logic              pred_valid,
   output logic              pred_hit,
   output logic [1:0]        pred_state,
   output logic              pred_taken,
   output logic [HIST_W-1:0] pred_ghr,
   input  logic              ex_valid,
   input  logic [PC_W-1:0]   ex_pc,
   input  logic              ex_taken,
   input  logic [HIST_W-1:0] ex_ghr,
   output logic              ready
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
   localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

   fsm_e             state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;

   logic             valid_q [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   ctr_t             ctr_q   [ENTRIES];

   logic [IDX_W-1:0] f_pc_idx, e_pc_idx, f_idx, e_idx;
   logic [TAG_W-1:0] f_tag, e_tag;
   logic             is_branch, upd_en, ex_hit;
   ctr_t             ctr_new;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == S_INIT) begin
         ptr_d = ptr_q + ONE_IDX;
         if (ptr_q == LAST_IDX) begin
            state_d = S_RUN;
            ptr_d   = '0;
         end
      end
   end

   assign ready  = (state_q == S_RUN);
   assign upd_en = ex_valid && ready;

   assign f_pc_idx = fetch_pc[IDX_W+1:2];
   assign f_tag    = fetch_pc[PC_W-1:IDX_W+2];
   assign e_pc_idx = ex_pc[IDX_W+1:2];
   assign e_tag    = ex_pc[PC_W-1:IDX_W+2];

`ifdef BHT_GSHARE_EN
   logic unused_ok;
   assign unused_ok = ^{fetch_inst[31:7], fetch_pc[1:0], ex_pc[1:0]};

   bht_ghr #(
      .IDX_W  (IDX_W),
      .HIST_W (HIST_W)
   ) u_ghr (
      .clk          (clk),
      .rst_n        (rst_n),
      .upd_en_i     (upd_en),
      .taken_i      (ex_taken),
      .fetch_idx_i  (f_pc_idx),
      .ex_idx_i     (e_pc_idx),
      .ex_ghr_i     (ex_ghr),
      .ghr_o        (pred_ghr),
      .fetch_hidx_o (f_idx),
      .ex_hidx_o    (e_idx)
   );
`else
   logic unused_ok;
   assign unused_ok = ^{fetch_inst[31:7], fetch_pc[1:0], ex_pc[1:0], ex_ghr};

   assign f_idx    = f_pc_idx;
   assign e_idx    = e_pc_idx;
   assign pred_ghr = '0;
`endif

   // Lookup reads the array directly: a same-cycle update is not bypassed.
   assign is_branch  = (fetch_inst[6:0] == BRANCH_OPCODE);
   assign pred_valid = ready && is_branch;
   assign pred_hit   = pred_valid && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign pred_state = pred_hit ? ctr_q[f_idx] : INIT_STATE;
   assign pred_taken = pred_state[1];

   // A miss allocates as if the entry had held INIT_STATE.
   assign ex_hit  = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
   assign ctr_new = sat_step(ex_hit ? ctr_q[e_idx] : INIT_STATE, ex_taken);

   always_ff @(posedge clk) begin
      if (state_q == S_INIT) begin
         valid_q[ptr_q] <= 1'b0;
         ctr_q[ptr_q]   <= INIT_STATE;
      end else if (upd_en) begin
         valid_q[e_idx] <= 1'b1;
         tag_q[e_idx]   <= e_tag;
         ctr_q[e_idx]   <= ctr_new;
      end
   end

endmodule

// File: tb/tb_bht_sat2.sv
// Self-checking bench for bht_sat2: randomized traffic against an
// array-based behavioural model plus directed reset/sweep/aliasing scenarios.
module tb_bht_sat2;

   localparam int ENTRIES = 256;
   localparam int PC_W    = 32;
   localparam int HIST_W  = 8;
   localparam int IDX_W   = 8;
   localparam logic [31:0] BEQ = 32'h0020_8063;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [PC_W-1:0]   fetch_pc = '0;
   logic [31:0]       fetch_inst = '0;
   logic              pred_valid, pred_hit, pred_taken, ready;
   logic [1:0]        pred_state;
   logic [HIST_W-1:0] pred_ghr;
   logic              ex_valid = 1'b0;
   logic [PC_W-1:0]   ex_pc = '0;
   logic              ex_taken = 1'b0;
   logic [HIST_W-1:0] ex_ghr = '0;

   int errors = 0;
   int checks = 0;

   bht_sat2 #(
      .ENTRIES(ENTRIES), .PC_W(PC_W), .HIST_W(HIST_W), .INIT_STATE(2'b01)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
      .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_state(pred_state),
      .pred_taken(pred_taken), .pred_ghr(pred_ghr),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_ghr(ex_ghr),
      .ready(ready)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit          m_valid [ENTRIES];
   int unsigned m_tag   [ENTRIES];
   int          m_ctr   [ENTRIES];
   int unsigned m_ghr;
   bit          m_ready;
   int          m_sweep;

   function automatic int m_index(logic [31:0] pc, int unsigned g);
      int i;
      i = int'((pc >> 2) % ENTRIES);
`ifdef BHT_GSHARE_EN
      i = i ^ int'(g % ENTRIES);
`endif
      return i;
   endfunction

   function automatic logic [4:0] m_pred(logic [31:0] pc, logic [31:0] inst);
      int i, s;
      bit v, h;
      v = m_ready && (inst[6:0] == 7'h63);
      i = m_index(pc, m_ghr);
      h = v && m_valid[i] && (m_tag[i] == (pc >> (IDX_W + 2)));
      s = h ? m_ctr[i] : 1;
      return {v, h, 2'(s), s >= 2};
   endfunction

   task automatic m_update(logic [31:0] pc, logic taken, int unsigned g);
      int i, base;
      i = m_index(pc, g);
      base = (m_valid[i] && m_tag[i] == (pc >> (IDX_W + 2))) ? m_ctr[i] : 1;
      base = taken ? ((base + 1 > 3) ? 3 : base + 1) : ((base - 1 < 0) ? 0 : base - 1);
      m_valid[i] = 1;
      m_tag[i]   = pc >> (IDX_W + 2);
      m_ctr[i]   = base;
      m_ghr      = ((m_ghr << 1) | 32'(taken)) % (1 << HIST_W);
   endtask

   task automatic m_clear();
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      m_ready = 0;
      m_sweep = 0;
      m_ghr   = 0;
   endtask

   // one clock: model observes the edge, returns at the following negedge
   task automatic cycle();
      @(posedge clk);
      if (rst_n) begin
         if (ex_valid && m_ready) m_update(ex_pc, ex_taken, ex_ghr);
         if (!m_ready) begin
            m_sweep++;
            if (m_sweep == ENTRIES) m_ready = 1;
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 1000) begin
         cycle();
         n++;
      end
   endtask

   function automatic logic [31:0] rand_pc();
      return (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2);
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ex_valid = 1'b0;
      m_clear();
      @(negedge clk);
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int n;
      logic [31:0] pcs[$];
      apply_reset();
      fetch_pc = 32'h1000; fetch_inst = BEQ;
      #1;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b want=0", ready); end
      checks++;
      if ({pred_valid, pred_hit, pred_state, pred_taken} !== 5'b00010) begin
         errors++; $display("FAIL reset_pred got=%b want=00010", {pred_valid, pred_hit, pred_state, pred_taken});
      end
      checks++;
      if (pred_ghr !== '0) begin errors++; $display("FAIL reset_ghr got=%h want=0", pred_ghr); end
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (!ready && n < 1000) begin
         ex_valid = $urandom_range(0, 1);
         ex_pc    = rand_pc();
         ex_taken = $urandom_range(0, 1);
         if (ex_valid) pcs.push_back(ex_pc);
         cycle();
         n++;
      end
      ex_valid = 1'b0;
      checks++;
      if (n != ENTRIES) begin errors++; $display("FAIL sweep_len got=%0d want=%0d", n, ENTRIES); end
      for (int k = 0; k < 8 && k < pcs.size(); k++) begin
         fetch_pc = pcs[k]; fetch_inst = BEQ;
         #1;
         checks++;
         if (pred_hit !== 1'b0) begin errors++; $display("FAIL sweep_drop pc=%h hit=%0b want=0", pcs[k], pred_hit); end
      end
   endtask

   task automatic test_cold();
      fetch_pc = 32'h0000_1000; fetch_inst = BEQ;
      #1;
      checks++;
      if ({pred_valid, pred_hit, pred_state, pred_taken} !== 5'b10010) begin
         errors++; $display("FAIL cold_lookup got=%b want=10010", {pred_valid, pred_hit, pred_state, pred_taken});
      end
      fetch_inst = 32'h0000_0013;
      #1;
      checks++;
      if ({pred_valid, pred_hit, pred_state} !== 4'b0001) begin
         errors++; $display("FAIL non_branch got=%b want=0001", {pred_valid, pred_hit, pred_state});
      end
   endtask

   task automatic test_saturate();
      logic [1:0] exp_s [8] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
      fetch_pc = 32'h1000; fetch_inst = BEQ;
      for (int k = 0; k < 8; k++) begin
         ex_valid = 1'b1; ex_pc = 32'h1000; ex_taken = (k < 4); ex_ghr = '0;
         cycle();
         ex_valid = 1'b0;
         #1;
         checks++;
         if ({pred_hit, pred_state, pred_taken} !== {1'b1, exp_s[k], exp_s[k][1]}) begin
            errors++; $display("FAIL saturate step=%0d got=%b want=%b", k,
                               {pred_hit, pred_state, pred_taken}, {1'b1, exp_s[k], exp_s[k][1]});
         end
      end
   endtask

   task automatic test_alias();
      ex_valid = 1'b1; ex_pc = 32'h1000; ex_taken = 1'b1;
      cycle();
      ex_pc = 32'h2000; ex_taken = 1'b0;
      cycle();
      ex_valid = 1'b0;
      fetch_pc = 32'h1000; fetch_inst = BEQ;
      #1;
      checks++;
      if ({pred_hit, pred_state} !== 3'b001) begin
         errors++; $display("FAIL alias_old got=%b want=001", {pred_hit, pred_state});
      end
      fetch_pc = 32'h2000;
      #1;
      checks++;
      if ({pred_hit, pred_state} !== 3'b100) begin
         errors++; $display("FAIL alias_new got=%b want=100", {pred_hit, pred_state});
      end
   endtask

   task automatic test_same_cycle();
      ex_valid = 1'b1; ex_pc = 32'h10; ex_taken = 1'b0;
      cycle();
      ex_taken = 1'b1;
      cycle();
      fetch_pc = 32'h10; fetch_inst = BEQ;
      #1;
      checks++;
      if ({pred_hit, pred_state} !== 3'b101) begin
         errors++; $display("FAIL same_cycle_pre got=%b want=101", {pred_hit, pred_state});
      end
      cycle();
      ex_valid = 1'b0;
      #1;
      checks++;
      if ({pred_hit, pred_state} !== 3'b110) begin
         errors++; $display("FAIL same_cycle_post got=%b want=110", {pred_hit, pred_state});
      end
   endtask

   task automatic test_random();
      logic [4:0]        exp;
      logic [HIST_W-1:0] exp_ghr;
      for (int k = 0; k < 400; k++) begin
         fetch_pc   = rand_pc();
         fetch_inst = ($urandom_range(0, 3) != 0) ? BEQ : $urandom;
         ex_valid   = $urandom_range(0, 1);
         ex_pc      = rand_pc();
         ex_taken   = $urandom_range(0, 1);
         ex_ghr     = HIST_W'($urandom_range(0, 255));
         #1;
         exp = m_pred(fetch_pc, fetch_inst);
`ifdef BHT_GSHARE_EN
         exp_ghr = HIST_W'(m_ghr);
`else
         exp_ghr = '0;
`endif
         checks++;
         if ({pred_valid, pred_hit, pred_state, pred_taken} !== exp) begin
            errors++; $display("FAIL random_pred k=%0d pc=%h got=%b want=%b", k, fetch_pc,
                               {pred_valid, pred_hit, pred_state, pred_taken}, exp);
         end
         checks++;
         if (pred_ghr !== exp_ghr) begin
            errors++; $display("FAIL random_ghr k=%0d got=%h want=%h", k, pred_ghr, exp_ghr);
         end
         cycle();
      end
      ex_valid = 1'b0;
   endtask

   task automatic test_mid_reset();
      int n;
      ex_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL run_reset_ready got=%0b want=0", ready); end
      m_clear();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) cycle();
      rst_n = 1'b0;
      m_clear();
      #1;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got=%0b want=0", ready); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready(n);
      checks++;
      if (n != ENTRIES) begin errors++; $display("FAIL mid_reset_sweep got=%0d want=%0d", n, ENTRIES); end
      fetch_pc = 32'h2000; fetch_inst = BEQ;
      #1;
      checks++;
      if ({pred_valid, pred_hit, pred_state} !== 4'b1001) begin
         errors++; $display("FAIL mid_reset_clear got=%b want=1001", {pred_valid, pred_hit, pred_state});
      end
   endtask

`ifdef BHT_GSHARE_EN
   task automatic test_gshare();
      int n;
      logic [4:0] exp;
      apply_reset();
      rst_n = 1'b1;
      wait_ready(n);
      for (int k = 0; k < 3; k++) begin
         ex_valid = 1'b1; ex_pc = 32'h1000; ex_taken = (k < 2); ex_ghr = pred_ghr;
         cycle();
      end
      ex_valid = 1'b0;
      #1;
      checks++;
      if (pred_ghr !== 8'b0000_0110) begin errors++; $display("FAIL gshare_ghr got=%b want=00000110", pred_ghr); end
      ex_valid = 1'b1; ex_pc = 32'h1000; ex_taken = 1'b1; ex_ghr = 8'h06;
      cycle();
      ex_valid = 1'b0;
      fetch_pc = 32'h1000; fetch_inst = BEQ;
      #1;
      exp = m_pred(fetch_pc, fetch_inst);
      checks++;
      if ({pred_valid, pred_hit, pred_state, pred_taken} !== exp) begin
         errors++; $display("FAIL gshare_lookup got=%b want=%b", {pred_valid, pred_hit, pred_state, pred_taken}, exp);
      end
   endtask
`endif

   initial begin
      m_clear();
      test_reset();
`ifndef BHT_GSHARE_EN
      test_cold();
      test_saturate();
      test_alias();
      test_same_cycle();
`endif
      test_random();
      test_mid_reset();
`ifdef BHT_GSHARE_EN
      test_gshare();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bht_sat2.md
Name: bht_sat2

Overview:
- Parametrised successor branch history table for the 5-stage core.
- Looks up a tagged 2-bit saturating counter combinationally for the fetched conditional branch.
- Updates the counter internally from execute-stage branch resolution; the controller no longer computes the next state.
- Adds valid bits, a post-reset table-init sweep, and optional gshare indexing.

Parameters:
- ENTRIES, 256, number of table entries; power of two, 16..4096.
- PC_W, 32, PC width. IDX_W = $clog2(ENTRIES); TAG_W = PC_W - IDX_W - 2.
- HIST_W, 8, global history length, 1..IDX_W; used only with gshare.
- INIT_STATE, 2'b01, counter value on allocation and on a miss prediction (weakly not-taken).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_pc  in  PC_W  PC of fetched instruction.
- fetch_inst  in  32  fetched instruction.
- pred_valid  out  1  fetch_inst is a conditional branch (opcode 7'b1100011) and ready=1.
- pred_hit  out  1  valid entry with matching tag.
- pred_state  out  2  counter used for prediction.
- pred_taken  out  1  pred_state[1].
- pred_ghr  out  HIST_W  history snapshot; carry down the pipe to ex_ghr.
- ex_valid  in  1  resolved conditional branch in execute.
- ex_pc  in  PC_W  PC of resolved branch.
- ex_taken  in  1  actual outcome.
- ex_ghr  in  HIST_W  pred_ghr captured at that branch's fetch.
- ready  out  1  table initialised; lookups and updates enabled.

Behaviour:
- Reset is asynchronous and active-low:
  - ready=0, ghr=0, sweep pointer=0, FSM=INIT.
  - Outputs in reset: pred_valid=0, pred_hit=0, pred_state=INIT_STATE, pred_taken=INIT_STATE[1], pred_ghr=0.
- FSM INIT:
  - One entry per cycle is written valid=0, counter=INIT_STATE, from index 0 up to ENTRIES-1.
  - After the last index, move to RUN.
  - INIT lasts exactly ENTRIES cycles after rst_n rises; ready=1 from the next cycle.
- FSM RUN: terminal until reset. A reset asserted mid-sweep or in RUN restarts the sweep at index 0.
- Lookup (combinational, zero latency): idx = fetch_pc[IDX_W+1:2]; tag = fetch_pc[PC_W-1:IDX_W+2].
  - Hit: pred_state = entry counter.
  - Miss, invalid, or pred_valid=0: pred_state = INIT_STATE and pred_hit = 0.
- Update, registered at posedge when ex_valid && ready:
  - idx and tag are taken from ex_pc.
  - Hit: counter saturating +1 if ex_taken, -1 otherwise. 2'b11 stays 2'b11 on taken; 2'b00 stays 2'b00 on not-taken.
  - Miss: allocate (replace) the entry with valid=1, the new tag, and counter = INIT_STATE stepped once by ex_taken.
- ex_valid while ready=0 is silently dropped; no table or ghr change.
- Fetch and update to the same index in the same cycle: fetch sees the pre-update value; there is no bypass. The write lands at the clock edge.
- No stall or backpressure; one update per cycle maximum.

Optional Feature:
- Macro BHT_GSHARE_EN defined:
  - Lookup index = fetch_pc[IDX_W+1:2] XOR zero-extended ghr.
  - Update index = ex_pc[IDX_W+1:2] XOR zero-extended ex_ghr.
  - Tags remain the PC high bits.
  - ghr <= {ghr[HIST_W-2:0], ex_taken} on each accepted update.
  - pred_ghr = ghr.
- Macro not defined:
  - Plain PC indexing; no ghr register.
  - pred_ghr is tied to 0 and ex_ghr is ignored.

Decomposition:
- Package bht_pkg:
  - ctr_t (logic [1:0]).
  - enum SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - BRANCH_OPCODE = 7'b1100011.
  - Function sat_step(ctr_t, logic taken) returning ctr_t.
- One sub-module, bht_ghr: the history shift register and index hash, instantiated only under BHT_GSHARE_EN.

Test Plan:
- Release rst_n, ENTRIES=256 -> ready=0 for exactly 256 cycles, then 1. Any ex_valid pulses during the sweep leave the table unchanged.
- Fetch beq, fetch_pc=0x0000_1000, cold table -> pred_valid=1, pred_hit=0, pred_state=2'b01, pred_taken=0.
- Four ex_valid updates ex_pc=0x1000, taken=1, then a lookup -> states 10,11,11,11; pred_hit=1, pred_taken=1. Then three not-taken updates -> state 00, and it saturates at 00.
- Aliasing: install ex_pc=0x1000 taken, then ex_pc=0x2000 (same idx, different tag) not-taken -> lookup 0x1000 misses (state 01); lookup 0x2000 hits with state 00.
- Same-cycle fetch and update at idx 0x04 (counter 01, taken) -> fetch sees 01; next cycle sees 10. Assert rst_n=0 mid-sweep at cycle 100 -> ready=0, and the sweep restarts for a full 256 cycles.
- BHT_GSHARE_EN, HIST_W=8: updates taken,taken,not-taken -> pred_ghr=8'b0000_0110. fetch_pc=0x1000 then indexes entry 0x00 XOR 0x06 = 0x06.
